wgt_pack_fifo: RTL

Parametrised weight-stream packer and buffer for the conv accelerator. Accepts IN_W-bit weight beats from the AXIS-side loader. Packs a run-time-selectable number of beats (1..RATIO_MAX) into one wide word and queues it in an internal first-word-fall-through FIFO for the PE array. It adds several features the fixed 3:1 weight buffer did not have:
- run-time ratio;
- back-pressure with almost-full margin, so beats are never lost;
- zero-padded flush of partial words;
- valid/ready output.

---
 rtl/wgt_pack_fifo.sv | 128 ++++++++++++
 1 files changed

// File: rtl/wgt_pack_fifo.sv
// Weight-stream packer: gathers 1..RATIO_MAX input beats into one wide word
// and queues it in a first-word-fall-through FIFO with almost-full back-pressure.
module wgt_pack_fifo #(
  parameter int IN_W         = 512,
  parameter int RATIO_MAX    = 3,
  parameter int DEPTH_LOG2   = 10,
  parameter int AFULL_MARGIN = 2,
  localparam int OUT_W       = IN_W * RATIO_MAX
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             op_start,
  input  logic                             end_conv,
  input  logic [$clog2(RATIO_MAX+1)-1:0]   cfg_ratio,
  input  logic                             flush,
  input  logic                             s_valid,
  input  logic [IN_W-1:0]                  s_data,
  output logic                             s_ready,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [OUT_W-1:0]                 m_data,
  output logic [DEPTH_LOG2:0]              fifo_cnt,
  output logic                             fifo_full
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int RW    = $clog2(RATIO_MAX + 1);
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state, state_nxt;
  logic [RW-1:0]         ratio, ratio_sat, slot;
  logic [OUT_W-1:0]      pack, pack_cur, push_word;
  logic                  push_pending;
  logic                  accept, word_done, push, pop;
  logic [OUT_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (end_conv)      state_nxt = IDLE;
    else if (op_start) state_nxt = RUN;
  end

  // The in-flight push counts against the margin so a word can never land on a full FIFO.
  always_comb begin
    s_ready = (state == RUN) &&
              ((int'(cnt) + int'(push_pending)) < (DEPTH - AFULL_MARGIN));
  end

  always_comb begin
    accept    = s_valid && s_ready;
    word_done = accept && (slot == ratio - RW'(1));
    push      = (state == RUN) && !end_conv && !op_start &&
                (word_done || (flush && (accept || (slot != '0))));
    ratio_sat = ((cfg_ratio == '0) || (cfg_ratio > RW'(RATIO_MAX))) ? RW'(RATIO_MAX) : cfg_ratio;
    pack_cur  = pack;
    if (accept) pack_cur[int'(slot)*IN_W +: IN_W] = s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ratio        <= RW'(RATIO_MAX);
      slot         <= '0;
      pack         <= '0;
      push_pending <= 1'b0;
      push_word    <= '0;
    end else if (end_conv) begin
      slot         <= '0;
      pack         <= '0;
      push_pending <= 1'b0;
    end else begin
      push_pending <= push;
      if (push) push_word <= pack_cur;
      // op_start drops the partial word, including a beat accepted in the same cycle.
      if (op_start) begin
        ratio <= ratio_sat;
        slot  <= '0;
        pack  <= '0;
      end else if (push) begin
        slot  <= '0;
        pack  <= '0;
      end else if (accept) begin
        slot  <= slot + RW'(1);
        pack  <= pack_cur;
      end
    end
  end

  assign pop = m_ready && (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (end_conv) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_pending) wr_ptr <= wr_ptr + 1'b1;
      if (pop)          rd_ptr <= rd_ptr + 1'b1;
      case ({push_pending, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_pending && !end_conv) mem[wr_ptr] <= push_word;
  end

  assign m_valid   = (cnt != '0);
  assign m_data    = mem[rd_ptr];
  assign fifo_cnt  = cnt;
  assign fifo_full = (cnt == CW'(DEPTH));

endmodule
